dpll_loop_filter: RTL
=====================

# dpll_loop_filter

Digital proportional-integral loop filter for the clock-wizard DPLL. Sits directly downstream of the phase-frequency detector. Synchronises the detector's `flagu`/`flagd` outputs into the system clock domain and turns each rising edge into a +1/−1 phase event. From these events it produces a saturating control word for the digitally controlled oscillator. An optional lock detector reports when the loop has settled into alternating up/down corrections.

## Interface
Parameters:
- `W`, 10: control word width (bits).
- `KP`, 8: proportional step added or subtracted on each event.
- `KI`, 1: integral step accumulated on each event.
- `CTRL_INIT`, 512: integrator and control word value after reset; must be < 2^W.
- `LOCK_CNT`, 64: consecutive alternating events required to declare lock.

Ports:
- `CLK`  in  1: system clock.
- `RESET`  in  1: asynchronous, active-high reset.
- `flagu`  in  1: PFD up flag, asynchronous to `CLK`.
- `flagd`  in  1: PFD down flag, asynchronous to `CLK`.
- `hold`  in  1: freeze the loop; the integrator keeps its value and events are discarded.
- `ctrl`  out  W: DCO control word, unsigned.
- `ctrl_valid`  out  1: one-cycle pulse on each cycle `ctrl` takes an event update.
- `locked`  out  1: lock indication.

## Operation
- **Synchronisers.** Two-flop synchroniser on each of `flagu` and `flagd`, reset to 0.
- **Edge detection.** A rising-edge detector on each synchronised flag produces `up_p` and `dn_p`.
- **Direction register.** `dir` is loaded every cycle:
  - `up_p` and not `dn_p` gives +1.
  - `dn_p` and not `up_p` gives −1.
  - Both or neither gives 0.
- **Update when `dir` ≠ 0 and `hold` = 0:**
  - `integ` ← clamp(`integ` + `dir`·`KI`, 0, 2^W−1).
  - `ctrl` ← clamp(new `integ` + `dir`·`KP`, 0, 2^W−1).
  - `ctrl_valid` = 1 for that cycle.
- **Arithmetic.** Use W+2-bit signed intermediates, then clamp. No wrap-around is permitted.
- **Between events.** `ctrl` holds its last value, so the P term persists until the next event.
- **`hold` = 1:**
  - `integ` is frozen and `ctrl` ← `integ` (P term removed).
  - `ctrl_valid` = 0.
  - Events with `hold` = 1 are dropped, not queued.
  - The synchroniser and edge pipeline keep running.
- **Simultaneous up and down** in the same cycle: treated as no event; no `ctrl_valid`.
- **Reset values:**
  - Synchroniser and edge flops: 0.
  - `dir`: 0.
  - `integ` and `ctrl`: `CTRL_INIT`.
  - `ctrl_valid`: 0.
  - `locked`: 0.
  - Lock counter and last-direction register: 0.
- **Reset mid-operation.** All state clears immediately and asynchronously. If a flag is already high when `RESET` deasserts, it registers as one rising edge, i.e. one event.

## Timing
- Edge 0 is the first `CLK` edge at which `flagu` is sampled high.
  - Synchroniser stage 2 goes high at edge 1.
  - `dir` loads at edge 2.
  - `integ`, `ctrl` and `ctrl_valid` update at edge 3.
  - Input-to-`ctrl` latency is 3 cycles.
- Events must be spaced at least 2 `CLK` cycles apart to be resolved individually. A flag held high produces exactly one event.
- `locked` updates on the same edge as `ctrl`.

## Configuration
- Macro `DPLL_LOCK_DETECT_EN`.
- **Defined:**
  - On each applied event, compare `dir` with the last applied direction.
  - If the direction is opposite and no clamp occurred, the counter increments, saturating at `LOCK_CNT`.
  - Otherwise the counter resets to 1 and `locked` clears on that edge.
  - `locked` = 1 while the counter equals `LOCK_CNT`.
  - `hold` does not change the counter.
- **Undefined:** the counter and last-direction logic are absent, and `locked` is tied to 0.

## Structure
- **Shared package `dpll_pkg`:**
  - direction encoding constants `DIR_UP`, `DIR_DN`, `DIR_NONE` (2-bit signed);
  - default `W` and `CTRL_INIT`;
  - a clamp function shared with the DCO.
- **Sub-module `dpll_sync_edge`:** two-flop synchroniser plus rising-edge detector, reset to 0, instantiated once per flag.
- The filter datapath and lock logic stay in `dpll_loop_filter`.

## Test plan
- **Reset:** assert `RESET` mid-run → `ctrl` = 512, `ctrl_valid` = 0 and `locked` = 0 immediately, before any `CLK` edge.
- **Single up event:** one `flagu` pulse → `ctrl` = 521 (integ 513 + 8) and one `ctrl_valid` pulse, both 3 cycles after sampling.
- **Saturation:** with `CTRL_INIT` = 1020, issue 5 up events → `integ` stops at 1023 and `ctrl` stays at 1023, with no wrap to 0.
- **Simultaneous flags:** `flagu` and `flagd` rise on the same `CLK` edge → `ctrl` unchanged and no `ctrl_valid`.
- **Hold:** one up event to 521, then `hold` = 1 → `ctrl` = 513 on the next cycle. A down event during hold → no change. Release `hold`, then a down event → `ctrl` = 504.
- **Lock detect (macro defined, `LOCK_CNT` = 4):**
  - Alternate up/down 4 times → `locked` = 1 on the 4th update.
  - A following repeated direction → `locked` = 0 on that update.

Source files
------------

// File: rtl/dpll_pkg.sv
// Shared DPLL definitions.
// Holds the phase-event direction encoding, the default control-word width
// and reset value, and the saturating clamp helpers that the loop filter and
// the DCO both use.
package dpll_pkg;

    typedef logic signed [1:0] dir_t;

    localparam dir_t DIR_NONE = 2'sb00;
    localparam dir_t DIR_UP   = 2'sb01;
    localparam dir_t DIR_DN   = 2'sb11;

    localparam int unsigned W_DEF         = 10;
    localparam int unsigned CTRL_INIT_DEF = 512;

    // Saturate a signed value into the unsigned range [0, 2^w-1]; w <= 30.
    function automatic int dpll_clamp(input int x, input int unsigned w);
        int maxv;
        maxv = (1 << w) - 1;
        if (x < 0) begin
            return 0;
        end
        if (x > maxv) begin
            return maxv;
        end
        return x;
    endfunction

    // True when dpll_clamp would change the value.
    function automatic logic dpll_clamp_hit(input int x, input int unsigned w);
        return (x < 0) || (x > ((1 << w) - 1));
    endfunction

endpackage

// File: rtl/dpll_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector for one PFD flag.
// Ports:
//   CLK, RESET : system clock, asynchronous active-high reset
//   d          : asynchronous flag input
//   rise_c     : one-cycle pulse on each synchronised rising edge (combinational)
// All flops reset to 0, so a flag already high when RESET drops is seen as
// one rising edge.
module dpll_sync_edge (
    input  logic CLK,
    input  logic RESET,
    input  logic d,
    output logic rise_c
);

    logic s1;
    logic s2;
    logic s2_q;

    // Synchroniser stages plus a delayed copy for edge detection.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1   <= d;
            s2   <= s1;
            s2_q <= s2;
        end
    end

    assign rise_c = s2 & ~s2_q;

endmodule

// File: rtl/dpll_loop_filter.sv
// Proportional-integral loop filter for the clock-wizard DPLL.
// Turns synchronised PFD up/down edges into +1/-1 phase events and produces a
// saturating DCO control word (integrator plus a persistent P term).
// Ports:
//   CLK, RESET   : system clock, asynchronous active-high reset
//   flagu, flagd : PFD up/down flags, asynchronous to CLK
//   hold         : freeze integrator, drop events, output integrator only
//   ctrl         : W-bit unsigned DCO control word
//   ctrl_valid   : one-cycle pulse when ctrl takes an event update
//   locked       : lock indication
// Configuration macro: DPLL_LOCK_DETECT_EN enables the alternating-event lock
// detector; when undefined, locked is tied to 0.
module dpll_loop_filter
    import dpll_pkg::*;
#(
    parameter int unsigned W         = W_DEF,
    parameter int unsigned KP        = 8,
    parameter int unsigned KI        = 1,
    parameter int unsigned CTRL_INIT = CTRL_INIT_DEF,
    parameter int unsigned LOCK_CNT  = 64
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         flagu,
    input  logic         flagd,
    input  logic         hold,
    output logic [W-1:0] ctrl,
    output logic         ctrl_valid,
    output logic         locked
);

    localparam int unsigned SW = W + 2;
    localparam logic signed [SW-1:0] KI_S = SW'(KI);
    localparam logic signed [SW-1:0] KP_S = SW'(KP);

    if ((64'(CTRL_INIT) >= (64'(1) << W)) || (LOCK_CNT == 0)) begin : g_bad_params
        $error("dpll_loop_filter: CTRL_INIT must be < 2**W and LOCK_CNT > 0");
    end

    logic up_p;
    logic dn_p;

    dpll_sync_edge u_sync_up (
        .CLK    (CLK),
        .RESET  (RESET),
        .d      (flagu),
        .rise_c (up_p)
    );

    dpll_sync_edge u_sync_dn (
        .CLK    (CLK),
        .RESET  (RESET),
        .d      (flagd),
        .rise_c (dn_p)
    );

    dir_t                 dir;
    dir_t                 dir_c;
    logic [W-1:0]         integ;
    logic [W-1:0]         integ_new;
    logic [W-1:0]         ctrl_new;
    logic signed [SW-1:0] ki_step;
    logic signed [SW-1:0] kp_step;
    logic signed [SW-1:0] integ_sum;
    logic signed [SW-1:0] ctrl_sum;
    logic                 upd_c;

    // Coincident up and down edges cancel to no event.
    always_comb begin
        dir_c = DIR_NONE;
        if (up_p && !dn_p) begin
            dir_c = DIR_UP;
        end else if (dn_p && !up_p) begin
            dir_c = DIR_DN;
        end
    end

    // PI update with signed headroom, clamped back into the unsigned range.
    always_comb begin
        ki_step   = (dir == DIR_UP) ? KI_S : -KI_S;
        kp_step   = (dir == DIR_UP) ? KP_S : -KP_S;
        integ_sum = $signed({2'b00, integ}) + ki_step;
        integ_new = W'(dpll_clamp(int'(integ_sum), W));
        ctrl_sum  = $signed({2'b00, integ_new}) + kp_step;
        ctrl_new  = W'(dpll_clamp(int'(ctrl_sum), W));
        upd_c     = (dir != DIR_NONE) && !hold;
    end

    // Direction register, integrator and control word.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dir        <= DIR_NONE;
            integ      <= W'(CTRL_INIT);
            ctrl       <= W'(CTRL_INIT);
            ctrl_valid <= 1'b0;
        end else begin
            dir        <= dir_c;
            ctrl_valid <= 1'b0;
            if (hold) begin
                ctrl <= integ;
            end else if (dir != DIR_NONE) begin
                integ      <= integ_new;
                ctrl       <= ctrl_new;
                ctrl_valid <= 1'b1;
            end
        end
    end

`ifdef DPLL_LOCK_DETECT_EN
    localparam int unsigned CW = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_CNT);

    logic [CW-1:0] lock_cnt;
    logic [CW-1:0] lock_cnt_nxt;
    dir_t          last_dir;
    logic          clamp_c;

    // Count consecutive direction reversals that did not saturate.
    always_comb begin
        clamp_c      = dpll_clamp_hit(int'(integ_sum), W) ||
                       dpll_clamp_hit(int'(ctrl_sum), W);
        lock_cnt_nxt = CW'(1);
        if ((dir == -last_dir) && !clamp_c) begin
            lock_cnt_nxt = (lock_cnt == LOCK_MAX) ? LOCK_MAX : lock_cnt + CW'(1);
        end
    end

    // Lock state advances only on applied events.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            lock_cnt <= '0;
            last_dir <= DIR_NONE;
            locked   <= 1'b0;
        end else if (upd_c) begin
            lock_cnt <= lock_cnt_nxt;
            last_dir <= dir;
            locked   <= (lock_cnt_nxt == LOCK_MAX);
        end
    end
`else
    assign locked = 1'b0;
`endif

endmodule
